// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: bubble encoding, reset PC, fetch FSM state encodings.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds; async active-high reset to a bubble.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
    end else if (bubble_i) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + 32'd4;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem requests, drives IF/ID under stall/flush.
// Optional FETCH_PERF_EN adds saturating stall-cycle and flush counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_addr_out,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  output logic        valid_id_out,
  output logic [31:0] instr_id_out,
  output logic [31:0] pc_id_out,
  output logic [31:0] pc_plus4_id_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles_out,
  output logic [31:0] perf_flush_count_out
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  buf_q;
  logic         req_vld_q;
  logic [31:0]  pc_next;

  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr;

  assign pc_next = pc_q + 32'd4;

  // IF/ID control: a flush squashes everywhere except DRAIN, where IF/ID already holds a bubble.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_rsp_data_in;
    if (flush_in) begin
      ifid_bubble = (state_q != ST_DRAIN);
    end else if (!stall_in) begin
      case (state_q)
        ST_FETCH: ifid_bubble = 1'b1;
        ST_WAIT: begin
          if (imem_rsp_valid_in) ifid_load = 1'b1;
          else                   ifid_bubble = 1'b1;
        end
        ST_HOLD: begin
          ifid_load  = 1'b1;
          ifid_instr = buf_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      buf_q     <= NOP_INSTR;
      req_vld_q <= 1'b0;
    end else if (flush_in) begin
      pc_q <= align_pc(redirect_pc_in);
      case (state_q)
        ST_FETCH: begin
          if (imem_req_ready_in) begin
            state_q   <= ST_DRAIN;
            req_vld_q <= 1'b0;
          end else begin
            state_q   <= ST_FETCH;
            req_vld_q <= 1'b1;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (imem_rsp_valid_in) begin
            state_q   <= ST_FETCH;
            req_vld_q <= 1'b1;
          end else begin
            state_q   <= ST_DRAIN;
            req_vld_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_FETCH;
          req_vld_q <= 1'b1;
        end
      endcase
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q   <= ST_FETCH;
          req_vld_q <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_req_ready_in) begin
            state_q   <= ST_WAIT;
            req_vld_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid_in) begin
            if (stall_in) begin
              buf_q   <= imem_rsp_data_in;
              state_q <= ST_HOLD;
            end else begin
              pc_q      <= pc_next;
              state_q   <= ST_FETCH;
              req_vld_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_in) begin
            pc_q      <= pc_next;
            state_q   <= ST_FETCH;
            req_vld_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (imem_rsp_valid_in) begin
            state_q   <= ST_FETCH;
            req_vld_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_BOOT;
          req_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid_out = req_vld_q;
  assign imem_addr_out      = pc_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (ifid_instr),
    .pc_i       (pc_q),
    .valid_o    (valid_id_out),
    .instr_o    (instr_id_out),
    .pc_o       (pc_id_out),
    .pc_plus4_o (pc_plus4_id_out)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      if (stall_in && !flush_in && perf_stall_q != 32'hFFFF_FFFF)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_in && perf_flush_q != 32'hFFFF_FFFF)
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles_out = perf_stall_q;
  assign perf_flush_count_out  = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random stall/flush/ready/latency traffic.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in = 1'b0;
  logic [31:0] imem_addr_out;
  logic        imem_rsp_valid_in = 1'b0;
  logic [31:0] imem_rsp_data_in = 32'h0;
  logic        valid_id_out;
  logic [31:0] instr_id_out;
  logic [31:0] pc_id_out;
  logic [31:0] pc_plus4_id_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles_out;
  logic [31:0] perf_flush_count_out;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .stall_in           (stall_in),
    .flush_in           (flush_in),
    .redirect_pc_in     (redirect_pc_in),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_addr_out      (imem_addr_out),
    .imem_rsp_valid_in  (imem_rsp_valid_in),
    .imem_rsp_data_in   (imem_rsp_data_in),
    .valid_id_out       (valid_id_out),
    .instr_id_out       (instr_id_out),
    .pc_id_out          (pc_id_out),
    .pc_plus4_id_out    (pc_plus4_id_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles_out (perf_stall_cycles_out),
    .perf_flush_count_out  (perf_flush_count_out)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          cnt = 0;
  int          lat = 1;
  logic [31:0] exp_pc = 32'h0;
  int          delivered = 0;
  int          nstall = 0;
  int          nflush = 0;

  // Instruction memory contents: a bijection of the address, 0x00A00093 at address 0.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h00A0_0093 ^ {a[26:0], a[31:27]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: memory model answers accepted requests after `lat` cycles,
  // and the reference model checks IF/ID and the request port against program order.
  task automatic step();
    logic        acc, pst, pfl, prst, pvld, preq, prdy;
    logic [31:0] prd, pins, ppc, pp4, paddr;
    acc   = imem_req_valid_out && imem_req_ready_in && !rst;
    pst   = stall_in;  pfl = flush_in;  prd = redirect_pc_in;  prst = rst;
    pvld  = valid_id_out;  pins = instr_id_out;  ppc = pc_id_out;  pp4 = pc_plus4_id_out;
    preq  = imem_req_valid_out;  prdy = imem_req_ready_in;  paddr = imem_addr_out;
    @(negedge clk);
    imem_rsp_valid_in = 1'b0;
    imem_rsp_data_in  = $urandom;
    if (acc) begin
      pend = 1'b1; pend_addr = paddr; cnt = lat;
    end
    if (pend) begin
      if (cnt <= 1) begin
        imem_rsp_valid_in = 1'b1;
        imem_rsp_data_in  = memf(pend_addr);
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (!prst && !rst) begin
      if (pfl) begin
        nflush++;
        chk("m_flush_vld", valid_id_out, 1'b0);
        chk("m_flush_ins", instr_id_out, NOP_INSTR_DEF);
        chk("m_flush_pc", pc_id_out, 32'h0);
        exp_pc = {prd[31:2], 2'b00};
      end else if (pst) begin
        nstall++;
        chk("m_hold_vld", valid_id_out, pvld);
        chk("m_hold_ins", instr_id_out, pins);
        chk("m_hold_pc", pc_id_out, ppc);
        chk("m_hold_pc4", pc_plus4_id_out, pp4);
      end else if (valid_id_out) begin
        chk("m_pc", pc_id_out, exp_pc);
        chk("m_ins", instr_id_out, memf(exp_pc));
        chk("m_pc4", pc_plus4_id_out, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else begin
        chk("m_bub_ins", instr_id_out, NOP_INSTR_DEF);
        chk("m_bub_pc", pc_id_out, 32'h0);
        chk("m_bub_pc4", pc_plus4_id_out, 32'h0);
      end
      if (preq && !prdy && !pfl) begin
        chk("m_req_stable_vld", imem_req_valid_out, 1'b1);
        chk("m_req_stable_addr", imem_addr_out, paddr);
      end
      if (imem_req_valid_out) begin
        chk("m_req_addr", imem_addr_out, exp_pc);
        chk("m_one_outstanding", pend, 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; imem_req_ready_in = 1'b1;
    imem_rsp_valid_in = 1'b0; pend = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vld", valid_id_out, 1'b0);
    chk("rst_ins", instr_id_out, NOP_INSTR_DEF);
    chk("rst_pc", pc_id_out, 32'h0);
    chk("rst_pc4", pc_plus4_id_out, 32'h0);
    chk("rst_req", imem_req_valid_out, 1'b0);
    rst = 1'b0;
    exp_pc = RESET_PC_DEF; nstall = 0; nflush = 0;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!valid_id_out && n < max) begin step(); n++; end
    chk("wait_valid", valid_id_out, 1'b1);
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!imem_req_valid_out && n < max) begin step(); n++; end
    chk("wait_req", imem_req_valid_out, 1'b1);
  endtask

  initial begin
    int d0;
    // Zero-wait memory: request in cycle 1, instruction visible in cycle 3.
    lat = 1;
    do_reset();
    chk("boot_noreq", imem_req_valid_out, 1'b0);
    step();
    chk("c1_req", imem_req_valid_out, 1'b1);
    chk("c1_addr", imem_addr_out, 32'h0);
    step();
    chk("c2_vld", valid_id_out, 1'b0);
    step();
    chk("c3_vld", valid_id_out, 1'b1);
    chk("c3_ins", instr_id_out, 32'h00A0_0093);
    chk("c3_pc", pc_id_out, 32'h0);
    chk("c3_pc4", pc_plus4_id_out, 32'h4);
    chk("c3_addr", imem_addr_out, 32'h4);

    // Stall for three cycles while the next response arrives.
    stall_in = 1'b1;
    step();
    chk("st_hold_ins", instr_id_out, 32'h00A0_0093);
    step();
    chk("st_hold_pc", pc_id_out, 32'h0);
    chk("hold_noreq1", imem_req_valid_out, 1'b0);
    step();
    chk("hold_noreq2", imem_req_valid_out, 1'b0);
    chk("st_hold_vld", valid_id_out, 1'b1);
    stall_in = 1'b0;
    step();
    chk("buf_vld", valid_id_out, 1'b1);
    chk("buf_ins", instr_id_out, memf(32'h4));
    chk("buf_pc", pc_id_out, 32'h4);
    chk("buf_next_addr", imem_addr_out, 32'h8);

    // Flush while waiting on a slow response; the late response must be dropped.
    lat = 3;
    step();
    flush_in = 1'b1; redirect_pc_in = 32'h0000_0103;
    step();
    flush_in = 1'b0;
    chk("fw_bub_vld", valid_id_out, 1'b0);
    chk("fw_bub_ins", instr_id_out, NOP_INSTR_DEF);
    chk("fw_drain_noreq", imem_req_valid_out, 1'b0);
    lat = 1;
    step();
    step();
    chk("fw_req_addr", imem_addr_out, 32'h100);
    step();
    step();
    chk("fw_first_pc", pc_id_out, 32'h100);
    chk("fw_first_ins", instr_id_out, memf(32'h100));

    // Flush and stall together in HOLD: flush wins.
    stall_in = 1'b1;
    step();
    step();
    chk("fh_hold_noreq", imem_req_valid_out, 1'b0);
    flush_in = 1'b1; redirect_pc_in = 32'h0000_2000;
    step();
    flush_in = 1'b0; stall_in = 1'b0;
    chk("fh_bub_vld", valid_id_out, 1'b0);
    chk("fh_req_vld", imem_req_valid_out, 1'b1);
    chk("fh_req_addr", imem_addr_out, 32'h2000);
    step();
    step();
    chk("fh_pc", pc_id_out, 32'h2000);
    chk("fh_ins", instr_id_out, memf(32'h2000));

    // Backpressure: request held steady while ready is low.
    imem_req_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_vld", imem_req_valid_out, 1'b1);
      chk("bp_addr", imem_addr_out, 32'h2004);
      step();
    end
    imem_req_ready_in = 1'b1;

    // Redirect to the top of the address space and wrap.
    flush_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFF;
    step();
    flush_in = 1'b0;
    wait_req(10);
    chk("wrap_addr_top", imem_addr_out, 32'hFFFF_FFFC);
    wait_valid(10);
    chk("wrap_pc", pc_id_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_id_out, 32'h0);
    wait_req(10);
    chk("wrap_next_addr", imem_addr_out, 32'h0);

`ifdef FETCH_PERF_EN
    do_reset();
    imem_req_ready_in = 1'b0;
    stall_in = 1'b1;
    repeat (5) step();
    stall_in = 1'b0; flush_in = 1'b1; redirect_pc_in = 32'h0;
    repeat (2) step();
    flush_in = 1'b0;
    chk("perf_stall", perf_stall_cycles_out, 32'd5);
    chk("perf_flush", perf_flush_count_out, 32'd2);
    imem_req_ready_in = 1'b1;
`endif

    // Reset mid-request, then a stray response during BOOT must be ignored.
    do_reset();
    lat = 2;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("mr_vld", valid_id_out, 1'b0);
    chk("mr_req", imem_req_valid_out, 1'b0);
    pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = RESET_PC_DEF;
    imem_rsp_valid_in = 1'b1; imem_rsp_data_in = 32'hBAD0_0BAD;
    chk("mr_boot_noreq", imem_req_valid_out, 1'b0);
    step();
    chk("mr_req_addr", imem_addr_out, 32'h0);
    chk("mr_bub", valid_id_out, 1'b0);
    lat = 1;
    wait_valid(10);
    chk("mr_ins", instr_id_out, memf(32'h0));

    // Random traffic against the program-order model.
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      stall_in          = ($urandom_range(3) == 0);
      flush_in          = ($urandom_range(11) == 0);
      redirect_pc_in    = $urandom;
      imem_req_ready_in = ($urandom_range(9) < 7);
      lat               = 1 + $urandom_range(2);
      step();
    end
    chk("liveness", (delivered - d0 > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
